// File: rtl/ibnal_seq_pkg.sv
// ibnal_seq_pkg
//   Shared definitions for the ibnalhaytham LA command sequencer:
//   command opcodes, command-word field positions, sequencer state
//   encoding and la_out status bit positions.
package ibnal_seq_pkg;

  // Command opcodes carried in la_in[30:28]; 6 and 7 are illegal.
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_START  = 3'd3;
  localparam logic [2:0] OP_ABORT  = 3'd4;
  localparam logic [2:0] OP_CLRERR = 3'd5;

  // Command word fields.
  localparam int CMD_TOGGLE  = 31;
  localparam int CMD_OP_HI   = 30;
  localparam int CMD_OP_LO   = 28;
  localparam int CMD_ADDR_HI = 27;
  localparam int CMD_ADDR_LO = 24;
  localparam int CMD_DATA_HI = 15;

  // Sequencer state, reported verbatim on la_out[30:29].
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // la_out status word layout.
  localparam int LA_ACK      = 31;
  localparam int LA_STATE_HI = 30;
  localparam int LA_STATE_LO = 29;
  localparam int LA_ERR      = 28;
  localparam int LA_DONE     = 27;
  localparam int LA_BUSY     = 26;
  localparam int LA_TIMEOUT  = 25;
  localparam int LA_RB_HI    = 15;

endpackage

// File: rtl/ibnalhaytham_cfg_regfile.sv
// ibnalhaytham_cfg_regfile
//   NREG x 16-bit configuration register file for the ibnalhaytham core.
//   One synchronous write port, one combinational read port, and every
//   register exposed on a flattened bus (register k at [16k+15:16k]).
// Ports
//   clk       in   1          clock, rising edge
//   rst       in   1          asynchronous active-high reset, clears all registers
//   we        in   1          write enable
//   waddr     in   AW         write address
//   wdata     in   16         write data
//   raddr     in   AW         read address
//   rdata     out  16         read data (combinational)
//   cfg_flat  out  NREG*16    flattened register contents
module ibnalhaytham_cfg_regfile
  import ibnal_seq_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [15:0]          wdata,
  input  logic [AW-1:0]        raddr,
  output logic [15:0]          rdata,
  output logic [NREG*16-1:0]   cfg_flat
);

  // Registers must reset to zero, so each word is its own flop group
  // rather than an inferred RAM.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_word
      logic [15:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign cfg_flat[16*gi +: 16] = word_reg;
    end
  endgenerate

  assign rdata = cfg_flat[{raddr, 4'b0000} +: 16];

endmodule

// File: rtl/ibnalhaytham_la_sequencer.sv
// ibnalhaytham_la_sequencer
//   Command sequencer between the Caravel logic-analyzer bus and the
//   ibnalhaytham core. Decodes toggle-strobed LA command words, owns the
//   core configuration registers, issues start/abort pulses and reports
//   status plus register readback on la_out.
//   Pipeline: command sampled at edge N, decoded at N+1, executed at N+2
//   (ack, state, cfg and pulses all change at N+2).
// Ports
//   wb_clk_i      in   1         system clock, rising edge
//   wb_rst_i      in   1         asynchronous active-high reset
//   la_in         in   32        command word: [31] toggle, [30:28] op, [27:24] addr, [15:0] data
//   la_oenb       in   32        LA output-enable bar; bits high are read as 0
//   la_out        out  32        [31] ack, [30:29] state, [28] err, [27] done,
//                                [26] busy, [25] timeout, [15:0] readback
//   cfg_o         out  NREG*16   flattened configuration registers
//   core_start_o  out  1         one-cycle start pulse
//   core_abort_o  out  1         one-cycle abort pulse
//   core_busy_i   in   1         core running
//   core_done_i   in   1         one-cycle completion pulse
// Build option
//   IBNAL_SEQ_TIMEOUT_EN: adds a TIMEOUT_W-bit run watchdog that aborts the
//   core when it saturates and raises la_out[25]. Without it la_out[25] is 0.
module ibnalhaytham_la_sequencer
  import ibnal_seq_pkg::*;
#(
  parameter int NREG      = 8,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [31:0]          la_in,
  input  logic [31:0]          la_oenb,
  output logic [31:0]          la_out,
  output logic [NREG*16-1:0]   cfg_o,
  output logic                 core_start_o,
  output logic                 core_abort_o,
  input  logic                 core_busy_i,
  input  logic                 core_done_i
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [4:0] NREG_L = 5'(NREG);

  // ---------------- sample stage (edge N) ----------------
  logic [31:0] la_masked;
  logic        unused_bits;

  assign la_masked   = la_in & ~la_oenb;
  assign unused_bits = ^la_masked[23:16];

  logic        samp_toggle_reg;
  logic        samp_gate_reg;
  logic [2:0]  samp_op_reg;
  logic [3:0]  samp_addr_reg;
  logic [15:0] samp_data_reg;

  // ---------------- decode stage (edge N+1) ----------------
  logic        last_toggle_reg;
  logic        cmd_valid_reg;
  logic [2:0]  cmd_op_reg;
  logic [3:0]  cmd_addr_reg;
  logic [15:0] cmd_data_reg;
  logic        new_cmd;

  // A toggle flip only counts while the CPU actually drives bit 31.
  assign new_cmd = samp_gate_reg && (samp_toggle_reg != last_toggle_reg);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      samp_toggle_reg <= 1'b0;
      samp_gate_reg   <= 1'b0;
      samp_op_reg     <= '0;
      samp_addr_reg   <= '0;
      samp_data_reg   <= '0;
      last_toggle_reg <= 1'b0;
      cmd_valid_reg   <= 1'b0;
      cmd_op_reg      <= '0;
      cmd_addr_reg    <= '0;
      cmd_data_reg    <= '0;
    end else begin
      samp_toggle_reg <= la_masked[CMD_TOGGLE];
      samp_gate_reg   <= ~la_oenb[CMD_TOGGLE];
      samp_op_reg     <= la_masked[CMD_OP_HI:CMD_OP_LO];
      samp_addr_reg   <= la_masked[CMD_ADDR_HI:CMD_ADDR_LO];
      samp_data_reg   <= la_masked[CMD_DATA_HI:0];
      cmd_valid_reg   <= new_cmd;
      if (new_cmd) begin
        last_toggle_reg <= samp_toggle_reg;
        cmd_op_reg      <= samp_op_reg;
        cmd_addr_reg    <= samp_addr_reg;
        cmd_data_reg    <= samp_data_reg;
      end
    end
  end

  // ---------------- execute stage (edge N+2) ----------------
  state_t      state_reg;
  logic        ack_reg;
  logic        err_reg;
  logic        done_reg;
  logic        busy_reg;
  logic        timeout_reg;
  logic [15:0] readback_reg;
  logic        start_reg;
  logic        abort_reg;

  logic        addr_ok;
  logic        cfg_we;
  logic        start_fire;
  logic        timeout_hit;
  logic [15:0] cfg_rdata;

  assign addr_ok    = ({1'b0, cmd_addr_reg} < NREG_L);
  // Config is frozen while the core runs.
  assign cfg_we     = cmd_valid_reg && (cmd_op_reg == OP_WRITE) && addr_ok
                      && (state_reg != ST_RUN);
  assign start_fire = cmd_valid_reg && (cmd_op_reg == OP_START) && (state_reg == ST_IDLE);

  ibnalhaytham_cfg_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .we       (cfg_we),
    .waddr    (cmd_addr_reg[AW-1:0]),
    .wdata    (cmd_data_reg),
    .raddr    (cmd_addr_reg[AW-1:0]),
    .rdata    (cfg_rdata),
    .cfg_flat (cfg_o)
  );

`ifdef IBNAL_SEQ_TIMEOUT_EN
  // Watchdog fires on the edge where it would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wdog_reg;

  assign timeout_hit = (state_reg == ST_RUN) && (wdog_reg == WDOG_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wdog_reg <= '0;
    end else if (start_fire) begin
      wdog_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      wdog_reg <= wdog_reg + TIMEOUT_W'(1);
    end
  end
`else
  // TIMEOUT_W stays in the parameter list so both builds instantiate alike.
  logic [TIMEOUT_W-1:0] unused_wdog;
  logic                 unused_start_fire;

  assign unused_wdog       = '0;
  assign unused_start_fire = start_fire;
  assign timeout_hit       = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_IDLE;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      readback_reg <= '0;
      start_reg    <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      abort_reg <= 1'b0;
      busy_reg  <= core_busy_i;

      // Autonomous transitions; a command decoded this cycle overrides
      // them below (ABORT beats a simultaneous core_done_i).
      case (state_reg)
        ST_RUN: begin
          if (core_done_i) begin
            state_reg <= ST_DONE;
          end else if (timeout_hit) begin
            state_reg   <= ST_IDLE;
            abort_reg   <= 1'b1;
            timeout_reg <= 1'b1;
            err_reg     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b1;
        end
        default: ;
      endcase

      if (cmd_valid_reg) begin
        ack_reg <= last_toggle_reg;
        case (cmd_op_reg)
          OP_NOP: ;
          OP_WRITE: begin
            if (!addr_ok || (state_reg == ST_RUN)) err_reg <= 1'b1;
          end
          OP_READ: begin
            readback_reg <= addr_ok ? cfg_rdata : 16'h0000;
            if (!addr_ok) err_reg <= 1'b1;
          end
          OP_START: begin
            if (state_reg == ST_IDLE) begin
              state_reg <= ST_RUN;
              start_reg <= 1'b1;
              done_reg  <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
          OP_ABORT: begin
            if (state_reg == ST_RUN) begin
              state_reg <= ST_IDLE;
              abort_reg <= 1'b1;
            end
          end
          OP_CLRERR: begin
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
          end
          default: err_reg <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    la_out                            = '0;
    la_out[LA_ACK]                    = ack_reg;
    la_out[LA_STATE_HI:LA_STATE_LO]   = state_reg;
    la_out[LA_ERR]                    = err_reg;
    la_out[LA_DONE]                   = done_reg;
    la_out[LA_BUSY]                   = busy_reg;
    la_out[LA_TIMEOUT]                = timeout_reg;
    la_out[LA_RB_HI:0]                = readback_reg;
  end

  assign core_start_o = start_reg;
  assign core_abort_o = abort_reg;

endmodule
